// File: rtl/wr_port_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : wr_port_sched_if
//  Description : Bundles the signals between the write-port scheduler, the
//                three video write ports and the AXI write controller.
//                master : scheduler side (drives the burst command)
//                slave  : port / write-controller side
//  Signals     : port_req[2:0]       port n holds at least one full burst
//                port_frame_rst[2:0] one-cycle frame restart per port
//                wr_cmd_done         one-cycle burst-complete pulse
//                wr_en               one-cycle burst command strobe
//                wr_addr             burst start address
//                wr_id / wr_len      burst ID {2'b00,port} / beats-1
//                wr_port / grant     current owner (binary / one-hot)
//                frame_done[2:0]     last burst of a frame written
//                buf_idx[2:0]        ping-pong buffer in use per port
//                wr_timeout          burst aborted
//  Revision    : 1.0  initial release
// ============================================================================
interface wr_port_sched_if #(
    parameter int CTRL_ADDR_WIDTH = 28
) ();
    logic [2:0]                 port_req;
    logic [2:0]                 port_frame_rst;
    logic                       wr_cmd_done;
    logic                       wr_en;
    logic [CTRL_ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]                 wr_id;
    logic [3:0]                 wr_len;
    logic [1:0]                 wr_port;
    logic [2:0]                 grant;
    logic [2:0]                 frame_done;
    logic [2:0]                 buf_idx;
    logic                       wr_timeout;

    modport master (
        input  port_req, port_frame_rst, wr_cmd_done,
        output wr_en, wr_addr, wr_id, wr_len, wr_port, grant,
               frame_done, buf_idx, wr_timeout
    );

    modport slave (
        output port_req, port_frame_rst, wr_cmd_done,
        input  wr_en, wr_addr, wr_id, wr_len, wr_port, grant,
               frame_done, buf_idx, wr_timeout
    );
endinterface
`default_nettype wire

// File: rtl/wr_port_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wr_port_sched
//  Description : Round-robin write-port scheduler for the DDR frame-buffer
//                write path. Picks one of three requesting video ports,
//                issues a single burst command, waits for completion (or
//                aborts after TIMEOUT cycles) and maintains per-port burst
//                address, frame position and ping-pong buffer index.
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                bus    wr_port_sched_if.master (requests, restarts, burst
//                       command, grant, frame/buffer status, timeout)
//  Revision    : 1.0  initial release
// ============================================================================
module wr_port_sched #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         BURST_LEN       = 16,
    parameter int                         BURST_ADDR_INC  = 128,
    parameter int                         FRAME_BURSTS    = 14400,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_SIZE      = 28'h0200000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] PORT0_BASE      = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] PORT1_BASE      = 28'h0400000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] PORT2_BASE      = 28'h0800000,
    parameter int                         TIMEOUT         = 1023
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    wr_port_sched_if.master    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    localparam int CNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]           LAST_BURST = CNT_W'(FRAME_BURSTS - 1);
    localparam logic [TO_W-1:0]            TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_INC   = CTRL_ADDR_WIDTH'(BURST_ADDR_INC);
    localparam logic [3:0]                 LEN_VAL    = 4'(BURST_LEN - 1);

    function automatic logic [CTRL_ADDR_WIDTH-1:0] port_base(input logic [1:0] n);
        case (n)
            2'd0:    return PORT0_BASE;
            2'd1:    return PORT1_BASE;
            default: return PORT2_BASE;
        endcase
    endfunction

    // Start address of buffer b of port n (burst 0 of a frame).
    function automatic logic [CTRL_ADDR_WIDTH-1:0] frame_start(input logic [1:0] n,
                                                               input logic       b);
        return port_base(n) + (b ? FRAME_SIZE : '0);
    endfunction

    logic [1:0]                 state_q,     state_d;
    logic [1:0]                 last_port_q, last_port_d;
    logic [1:0]                 wr_port_q,   wr_port_d;
    logic [2:0]                 grant_q,     grant_d;
    logic [CTRL_ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic                       wr_en_q,     wr_en_d;
    logic [TO_W-1:0]            to_cnt_q,    to_cnt_d;
    logic [CNT_W-1:0]           burst_cnt_q [0:2];
    logic [CNT_W-1:0]           burst_cnt_d [0:2];
    logic [CTRL_ADDR_WIDTH-1:0] addr_q      [0:2];
    logic [CTRL_ADDR_WIDTH-1:0] addr_d      [0:2];
    logic [2:0]                 buf_idx_q,    buf_idx_d;
    logic [2:0]                 pend_q,       pend_d;
    logic [2:0]                 frame_done_q, frame_done_d;
    logic                       wr_timeout_q, wr_timeout_d;

    // Burst retirement (completion or abort) for the port owning the path.
    logic                       retire;
    logic                       found;
    logic [1:0]                 win;
    int                         cand;

    always_comb begin
        state_d      = state_q;
        last_port_d  = last_port_q;
        wr_port_d    = wr_port_q;
        grant_d      = grant_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        to_cnt_d     = to_cnt_q;
        buf_idx_d    = buf_idx_q;
        pend_d       = pend_q;
        frame_done_d = '0;
        wr_timeout_d = 1'b0;
        retire       = 1'b0;
        found        = 1'b0;
        win          = 2'd0;
        cand         = 0;
        for (int n = 0; n < 3; n++) begin
            burst_cnt_d[n] = burst_cnt_q[n];
            addr_d[n]      = addr_q[n];
        end

        // Restarts of ports not owning the path take effect at once; the
        // owner defers its restart until the burst in flight retires.
        for (int n = 0; n < 3; n++) begin
            if (bus.port_frame_rst[n]) begin
                if (grant_q[n]) begin
                    pend_d[n] = 1'b1;
                end else begin
                    burst_cnt_d[n] = '0;
                    addr_d[n]      = frame_start(2'(n), buf_idx_q[n]);
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                for (int k = 1; k <= 3; k++) begin
                    cand = (int'(last_port_q) + k) % 3;
                    if (!found && bus.port_req[cand]) begin
                        found = 1'b1;
                        win   = 2'(cand);
                    end
                end
                if (found) begin
                    wr_port_d = win;
                    grant_d   = 3'b001 << win;
                    // addr_d already reflects a restart arriving this cycle
                    wr_addr_d = addr_d[win];
                    wr_en_d   = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                // Completion wins over a timeout expiring in the same cycle.
                if (bus.wr_cmd_done) begin
                    retire      = 1'b1;
                    last_port_d = wr_port_q;
                end else if (to_cnt_q == TO_LAST) begin
                    retire       = 1'b1;
                    wr_timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            grant_d = '0;
            state_d = S_IDLE;
            if (pend_q[wr_port_q] || bus.port_frame_rst[wr_port_q]) begin
                // Restart overrides both the advance and the frame wrap.
                pend_d[wr_port_q]      = 1'b0;
                burst_cnt_d[wr_port_q] = '0;
                addr_d[wr_port_q]      = frame_start(wr_port_q, buf_idx_q[wr_port_q]);
            end else if (bus.wr_cmd_done) begin
                if (burst_cnt_q[wr_port_q] == LAST_BURST) begin
                    burst_cnt_d[wr_port_q]  = '0;
                    buf_idx_d[wr_port_q]    = ~buf_idx_q[wr_port_q];
                    addr_d[wr_port_q]       = frame_start(wr_port_q, ~buf_idx_q[wr_port_q]);
                    frame_done_d[wr_port_q] = 1'b1;
                end else begin
                    burst_cnt_d[wr_port_q] = burst_cnt_q[wr_port_q] + CNT_W'(1);
                    addr_d[wr_port_q]      = addr_q[wr_port_q] + ADDR_INC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_port_q  <= 2'd2;
            wr_port_q    <= 2'd0;
            grant_q      <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            to_cnt_q     <= '0;
            buf_idx_q    <= '0;
            pend_q       <= '0;
            frame_done_q <= '0;
            wr_timeout_q <= 1'b0;
            for (int n = 0; n < 3; n++) begin
                burst_cnt_q[n] <= '0;
                addr_q[n]      <= port_base(2'(n));
            end
        end else begin
            state_q      <= state_d;
            last_port_q  <= last_port_d;
            wr_port_q    <= wr_port_d;
            grant_q      <= grant_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            to_cnt_q     <= to_cnt_d;
            buf_idx_q    <= buf_idx_d;
            pend_q       <= pend_d;
            frame_done_q <= frame_done_d;
            wr_timeout_q <= wr_timeout_d;
            for (int n = 0; n < 3; n++) begin
                burst_cnt_q[n] <= burst_cnt_d[n];
                addr_q[n]      <= addr_d[n];
            end
        end
    end

    // wr_addr is held after the strobe; only meaningful while wr_en is high.
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_id      = {2'b00, wr_port_q};
    assign bus.wr_len     = LEN_VAL;
    assign bus.wr_port    = wr_port_q;
    assign bus.grant      = grant_q;
    assign bus.frame_done = frame_done_q;
    assign bus.buf_idx    = buf_idx_q;
    assign bus.wr_timeout = wr_timeout_q;

endmodule
`default_nettype wire
